// File: rtl/ram_responder_pkg.sv
// ram_responder shared types and sizes.
// Memory geometry defaults and the responder state encoding.
package ram_responder_pkg;

  localparam int MEMORY_ADDRESS_BITS = 8;
  localparam int MEMORY_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    MEM_CLEAR,
    MEM_LOAD,
    MEM_RUN
  } MemState;

endpackage

// File: rtl/ram_responder_ram_1r1w.sv
// ram_1r1w: plain storage, one registered read, one write.
// Read-first on same-address collision; no reset on the array.
module ram_1r1w #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rd_data;

  // array write and registered read; read sees pre-edge contents
  always_ff @(posedge clk) begin
    if (i_wr_en)
      r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en)
      r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ram_responder.sv
// ram_responder: clear, host image load, then core read/write service.
// Holds the core in reset until the image has been loaded.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int ADDR_BITS = MEMORY_ADDRESS_BITS,
  parameter int DATA_BITS = MEMORY_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_ram_en,
  input  logic [ADDR_BITS-1:0] rd_ram_addr,
  output logic [DATA_BITS-1:0] rd_ram_data,
  input  logic                 wr_ram_en,
  input  logic [ADDR_BITS-1:0] wr_ram_addr,
  input  logic [DATA_BITS-1:0] wr_ram_data,
  input  logic                 ld_valid,
  input  logic [DATA_BITS-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic [ADDR_BITS:0]   ld_count,
  output logic                 ld_error,
  output logic                 cpu_hold
);

  localparam logic [ADDR_BITS-1:0] LP_PTR_LAST = '1;
  localparam logic [ADDR_BITS-1:0] LP_PTR_ONE  = 1;
  localparam logic [ADDR_BITS:0]   LP_CNT_ONE  = 1;

  MemState              r_state;
  logic [ADDR_BITS-1:0] r_clr_ptr;
  logic [ADDR_BITS-1:0] r_ld_ptr;
  logic [ADDR_BITS:0]   r_ld_count;
  logic                 r_ld_ready;
  logic                 r_ld_error;
  logic                 r_cpu_hold;
  logic                 r_rd_seen;

  logic                 w_ld_xfer;
  logic                 w_rd_en;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_waddr;
  logic [DATA_BITS-1:0] w_wdata;
  logic [DATA_BITS-1:0] w_rd_q;

  assign w_ld_xfer = ld_valid & r_ld_ready;
  assign w_rd_en   = rd_ram_en & (r_state == MEM_RUN);

  // write-port owner follows the state: clear, loader, or core
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    case (r_state)
      MEM_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_ptr;
      end
      MEM_LOAD: begin
        w_we    = w_ld_xfer;
        w_waddr = r_ld_ptr;
        w_wdata = ld_data;
      end
      MEM_RUN: begin
        w_we    = wr_ram_en;
        w_waddr = wr_ram_addr;
        w_wdata = wr_ram_data;
      end
      default: ;
    endcase
  end

  // sequencer: clear sweep, load handshake, then run until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= MEM_CLEAR;
      r_clr_ptr  <= '0;
      r_ld_ptr   <= '0;
      r_ld_count <= '0;
      r_ld_ready <= 1'b0;
      r_ld_error <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_rd_seen  <= 1'b0;
    end else begin
      case (r_state)
        MEM_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + LP_PTR_ONE;
          if (r_clr_ptr == LP_PTR_LAST) begin
            r_state    <= MEM_LOAD;
            r_ld_ready <= 1'b1;
          end
        end
        MEM_LOAD: begin
          if (w_ld_xfer) begin
            r_ld_ptr   <= r_ld_ptr + LP_PTR_ONE;
            r_ld_count <= r_ld_count + LP_CNT_ONE;
            if (ld_last || r_ld_ptr == LP_PTR_LAST) begin
              r_state    <= MEM_RUN;
              r_ld_ready <= 1'b0;
              r_cpu_hold <= 1'b0;
              r_ld_error <= ~ld_last;
            end
          end
        end
        MEM_RUN: begin
          if (rd_ram_en)
            r_rd_seen <= 1'b1;
        end
        default: r_state <= MEM_CLEAR;
      endcase
    end
  end

  ram_1r1w #(
    .AW(ADDR_BITS),
    .DW(DATA_BITS)
  ) u_ram (
    .clk      (clk),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(rd_ram_addr),
    .o_rd_data(w_rd_q),
    .i_wr_en  (w_we),
    .i_wr_addr(w_waddr),
    .i_wr_data(w_wdata)
  );

  // read register has no reset; mask it until the first run read
  assign rd_ram_data = r_rd_seen ? w_rd_q : '0;
  assign ld_ready    = r_ld_ready;
  assign ld_count    = r_ld_count;
  assign ld_error    = r_ld_error;
  assign cpu_hold    = r_cpu_hold;

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
Byte-wide, single-clock memory that serves the execution unit's memory read and write ports. It acts as the responder to the core's read/write initiator.
- Out of reset it clears its array, then accepts a program image from a host load port.
- It holds the core in reset (cpu_hold) until loading finishes, then enters RUN and serves core transactions.

Parameters:
ADDR_BITS, 8 (MEMORY_ADDRESS_BITS), address width; depth = 2**ADDR_BITS
DATA_BITS, 8 (MEMORY_DATA_BITS), byte width

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset, sampled on rising edge of clk
rd_ram_en  in  1  core read request, sampled at edge
rd_ram_addr  in  ADDR_BITS  core read address
rd_ram_data  out  DATA_BITS  registered read data
wr_ram_en  in  1  core write request, sampled at edge
wr_ram_addr  in  ADDR_BITS  core write address
wr_ram_data  in  DATA_BITS  core write data
ld_valid  in  1  host load byte valid
ld_data  in  DATA_BITS  host load byte
ld_last  in  1  marks final byte of the image (qualified by ld_valid)
ld_ready  out  1  block accepts a load byte this cycle
ld_count  out  ADDR_BITS+1  number of bytes accepted in the current load
ld_error  out  1  sticky: image overflowed the array
cpu_hold  out  1  keeps the core in reset while high

Behaviour:
- The only sequential element that is not reset is the storage array. All outputs and state are cleared by reset.
- Reset values:
  - state = CLEAR, clear pointer = 0, load pointer = 0
  - rd_ram_data = 0, ld_ready = 0, ld_count = 0, ld_error = 0, cpu_hold = 1
- States: CLEAR -> LOAD -> RUN. RUN is left only by reset.
- Reset asserted in any state, including mid-CLEAR or mid-LOAD, returns to CLEAR with all pointers zeroed. A partial image is then overwritten by the clear.
- CLEAR:
  - Each cycle writes 0 to mem[clear_ptr] and increments clear_ptr.
  - After writing address 2**ADDR_BITS-1 (2**ADDR_BITS cycles in total), the next state is LOAD.
  - ld_ready = 0.
- LOAD:
  - ld_ready = 1, registered; it is 1 in the first LOAD cycle.
  - Handshake: a byte transfers on an edge where ld_valid & ld_ready.
  - On transfer: mem[load_ptr] <= ld_data, load_ptr++, ld_count++.
  - Transfer with ld_last = 1: the next state is RUN. ld_ready drops in the same edge.
  - Transfer at load_ptr = 2**ADDR_BITS-1 with ld_last = 0: the byte is written, ld_error <= 1, next state is RUN. There is no wrap and no overwrite of address 0.
  - ld_last with ld_valid = 0 is ignored.
  - ld_count holds its final value through RUN.
- cpu_hold: 1 in CLEAR and LOAD. It deasserts registered, i.e. 0 from the first RUN cycle.
- RUN, read:
  - If rd_ram_en is sampled high at edge N, then rd_ram_data = mem[rd_ram_addr] after edge N. Latency is 1 cycle.
  - If rd_ram_en is low, rd_ram_data holds its previous value.
- RUN, write: if wr_ram_en is sampled high, mem[wr_ram_addr] <= wr_ram_data at that edge.
- Simultaneous read and write to the same address: read-first. rd_ram_data returns the old contents and the new value is visible on the following read.
- Simultaneous read and write to different addresses: both complete in the same cycle.
- Core rd/wr enables are ignored outside RUN: no array change, rd_ram_data holds.
- Host ld_valid is ignored outside LOAD.
- Addresses are unsigned and exactly ADDR_BITS wide; there is no out-of-range case.

Decomposition:
- Add to constants_pkg: typedef enum bit [1:0] {MEM_CLEAR, MEM_LOAD, MEM_RUN} MemState.
- Reuse MEMORY_ADDRESS_BITS and MEMORY_DATA_BITS as the parameter defaults.
- One sub-module: ram_1r1w. Plain array, one registered read port with enable, one write port, read-first, no reset.
- ram_responder contains the FSM, the pointers, and the write-port mux:
  - CLEAR: clear_ptr with 0
  - LOAD: load_ptr with ld_data
  - RUN: core write

Test Plan:
- Reset, then hold ld_valid = 0 -> cpu_hold = 1 and ld_ready = 0 for 256 cycles; ld_ready = 1 in cycle 257.
- Load bytes 0xA1, 0x0F, 0x33 with ld_last on the third byte -> ld_count = 3, cpu_hold = 0 on the next cycle; reads of addresses 0, 1, 2, 3 return 0xA1, 0x0F, 0x33, 0x00, each one cycle after rd_ram_en.
- In RUN, same edge: write 0x55 to 0x10 and read 0x10 (old contents 0x00) -> rd_ram_data = 0x00; a read of 0x10 on the next cycle returns 0x55.
- Stream 257 bytes (value = index) with no ld_last -> ld_error = 1, ld_count = 256, RUN entered after the 256th byte; address 0 still holds 0x00.
- Assert reset after 5 load bytes, then load a single byte 0x77 with ld_last -> the full CLEAR runs again; address 0 = 0x77, address 4 = 0x00, ld_error = 0.
- In RUN, pulse rd_ram_en for address 0x02, then idle 3 cycles while changing rd_ram_addr -> rd_ram_data holds the 0x02 contents; wr_ram_en asserted during LOAD leaves memory unchanged.
